// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Clock cycles in one full UART bit.
    function automatic int unsigned bit_cycles(input int unsigned clk_per_half_bit);
        return 2 * clk_per_half_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock show-ahead FIFO with registered level/full/empty flags.
module uart_tx_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      head_c,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LVL_W-1:0]      level_next;
    logic                  push;
    logic                  pop;

    // Flags are sampled before the edge, so a write into a full FIFO is dropped even alongside a pop.
    assign push   = wr_en && !full;
    assign pop    = rd_en && !empty;
    assign head_c = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            level <= level_next;
            full  <= (level_next == LVL_W'(DEPTH));
            empty <= (level_next == LVL_W'(0));
        end
    end

endmodule

// File: rtl/uart_tx_unit.sv
// Buffered UART transmitter: FIFO plus 8N1 serializer, LSB first.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_HALF_BIT = 86,
    parameter int unsigned FIFO_DEPTH_LOG2  = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [7:0]                 din,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       empty,
    output logic [FIFO_DEPTH_LOG2:0]   level,
    output logic                       tx_busy,
    output logic                       txd
);

    localparam int unsigned BIT_CYCLES = bit_cycles(CLK_PER_HALF_BIT);
    localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned IDX_W      = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_t      state;
    tx_state_t      state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [7:0]     shift;
    logic [7:0]     head_c;
    logic           bit_end_c;
    logic           pop_c;
    logic           txd_c;
`ifdef UART_TX_PARITY_EN
    logic           parity;
`endif

    uart_tx_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .din    (din),
        .wr_en  (wr_en),
        .rd_en  (pop_c),
        .head_c (head_c),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    assign bit_end_c = (bit_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (!empty) state_next = START;
            START:  if (bit_end_c) state_next = DATA;
            DATA: begin
                if (bit_end_c && bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end_c) state_next = STOP;
`endif
            // Chain straight into the next frame so there is no idle gap.
            STOP:   if (bit_end_c) state_next = empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop_c = 1'b0;
        txd_c = IDLE_LEVEL;
        case (state)
            IDLE:   pop_c = !empty;
            START:  txd_c = 1'b0;
            DATA:   txd_c = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_c = parity;
`endif
            STOP:   pop_c = bit_end_c && !empty;
            default: begin
                pop_c = 1'b0;
                txd_c = IDLE_LEVEL;
            end
        endcase
    end

    // Bit timing, shift register and the registered line outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= IDLE_LEVEL;
            tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            txd     <= txd_c;
            tx_busy <= (state != IDLE);

            if (state == IDLE || bit_end_c) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_end_c) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end

            if (pop_c) begin
                shift <= head_c;
`ifdef UART_TX_PARITY_EN
                parity <= ^head_c;
`endif
            end else if (state == DATA && bit_end_c) begin
                shift <= shift >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: line decoder feeds a scoreboard of written bytes.
module tb_uart_tx_unit;

    localparam int BIT_CYC    = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC  = FRAME_BITS * BIT_CYC;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       tx_busy;
    logic       txd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]  exp_q[$];
    logic [10:0] rx_q[$];
    int          start_q[$];
    int          rx_rd = 0;

    logic        txd_d = 1'b1;
    logic        mon_act = 1'b0;
    int          mon_p = 0;
    logic [10:0] mon_frame = '1;

    uart_tx_unit #(
        .CLK_PER_HALF_BIT (4),
        .FIFO_DEPTH_LOG2  (4)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .din     (din),
        .wr_en   (wr_en),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .tx_busy (tx_busy),
        .txd     (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: detects a start edge and samples each bit at its middle.
    always @(negedge clk) begin
        if (!rstn) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (txd_d && !txd) begin
                mon_act   = 1'b1;
                mon_p     = 0;
                mon_frame = '1;
                start_q.push_back(cyc);
            end
        end else begin
            mon_p++;
        end
        if (mon_act && (mon_p % BIT_CYC) == BIT_CYC / 2) begin
            mon_frame[mon_p / BIT_CYC] = txd;
            if (mon_p / BIT_CYC == FRAME_BITS - 1) begin
                rx_q.push_back(mon_frame);
                mon_act = 1'b0;
            end
        end
        txd_d = txd;
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic accept);
        din   = b;
        wr_en = 1'b1;
        step(1);
        wr_en = 1'b0;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step(1);
    endtask

    // Compare decoded frames against the scoreboard until the transmitter is idle.
    task automatic drain(input int budget);
        int         waited = 0;
        logic [7:0] e;
        logic [10:0] f;
        while ((exp_q.size() != 0 || tx_busy || !empty) && waited < budget) begin
            step(1);
            waited++;
            while (rx_rd < rx_q.size() && exp_q.size() != 0) begin
                f = rx_q[rx_rd];
                rx_rd++;
                e = exp_q.pop_front();
                check("frame_start", 32'(f[0]), 32'd0);
                check("frame_data", 32'(f[8:1]), 32'(e));
                check("frame_stop", 32'(f[FRAME_BITS-1]), 32'd1);
`ifdef UART_TX_PARITY_EN
                check("frame_parity", 32'(f[9]), 32'(^e));
`endif
            end
        end
        check("drain_timeout", 32'(waited < budget), 32'd1);
        step(4);
        check("extra_frames", 32'(rx_q.size() - rx_rd), 32'd0);
    endtask

    initial begin
        int w;
        int s0;
        int diff;

        // Reset state
        step(2);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rstn = 1'b1;
        step(2);

        // Single byte: latency, start bit width, busy window
        write_byte(8'h55, 1'b1);
        check("wr_empty", 32'(empty), 32'd0);
        check("wr_level", 32'(level), 32'd1);
        step(1);
        check("pop_level", 32'(level), 32'd0);
        check("pre_start_txd", 32'(txd), 32'd1);
        check("pre_start_busy", 32'(tx_busy), 32'd0);
        step(1);
        check("start_txd", 32'(txd), 32'd0);
        check("start_busy", 32'(tx_busy), 32'd1);
        step(7);
        check("start_end_txd", 32'(txd), 32'd0);
        step(1);
        check("bit0_txd", 32'(txd), 32'd1);
        step(FRAME_CYC - 9);
        check("last_cyc_txd", 32'(txd), 32'd1);
        check("last_cyc_busy", 32'(tx_busy), 32'd1);
        step(1);
        check("busy_drop", 32'(tx_busy), 32'd0);
        drain(200);

        // Back-to-back frames
        s0 = start_q.size();
        write_byte(8'hA5, 1'b1);
        write_byte(8'h3C, 1'b1);
        drain(3 * FRAME_CYC);
        check("b2b_starts", 32'(start_q.size() - s0), 32'd2);
        diff = (start_q.size() >= s0 + 2) ? start_q[s0+1] - start_q[s0] : -1;
        check("b2b_spacing", 32'(diff), 32'(FRAME_CYC));

        // Fill and overflow
        w = 0;
        for (int i = 0; i < 18; i++) begin
            write_byte(8'(i), i < 17);
            if (i == 0) w = cyc;
            if (i == 16) begin
                check("fill_full", 32'(full), 32'd1);
                check("fill_level", 32'(level), 32'd16);
            end
        end
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_full", 32'(full), 32'd1);

        // Write on the pop cycle while full: dropped, level falls by one
        wait_cyc(w + FRAME_CYC);
        check("popcyc_full", 32'(full), 32'd1);
        din   = 8'hEE;
        wr_en = 1'b1;
        step(1);
        wr_en = 1'b0;
        check("popcyc_level", 32'(level), 32'd15);
        check("popcyc_notfull", 32'(full), 32'd0);
        drain(18 * FRAME_CYC + 200);

        // Reset during data bit 3 of 0xF0 with more bytes queued
        write_byte(8'hF0, 1'b1);
        w = cyc;
        for (int i = 1; i < 5; i++) write_byte(8'(i), 1'b1);
        wait_cyc(w + 2 + 4 * BIT_CYC + 3);
        check("bit3_txd", 32'(txd), 32'd0);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        check("mid_rst_txd", 32'(txd), 32'd1);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        exp_q.delete();
        rx_rd = rx_q.size();
        s0 = start_q.size();
        step(3 * FRAME_CYC);
        check("post_rst_starts", 32'(start_q.size() - s0), 32'd0);
        check("post_rst_txd", 32'(txd), 32'd1);
        check("post_rst_busy", 32'(tx_busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity bit sits after data bit 7
        write_byte(8'h07, 1'b1);
        w = cyc;
        wait_cyc(w + 2 + 9 * BIT_CYC + 4);
        check("parity_07", 32'(txd), 32'd1);
        drain(2 * FRAME_CYC);
        write_byte(8'h03, 1'b1);
        w = cyc;
        wait_cyc(w + 2 + 9 * BIT_CYC + 4);
        check("parity_03", 32'(txd), 32'd0);
        drain(2 * FRAME_CYC);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
Buffered UART transmitter that sends bytes out on the serial line. It is the transmit-side counterpart of the receive unit.
- A core writes bytes into an internal synchronous FIFO.
- A transmit FSM drains the FIFO and serializes each byte as 8N1 on txd, LSB first.
- Everything runs on one clock domain; bit timing is derived from the same clock.

Parameters:
CLK_PER_HALF_BIT, 86, clk cycles per half UART bit; one bit lasts BIT_CYCLES = 2*CLK_PER_HALF_BIT cycles.
FIFO_DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 16 entries by default.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  reset; synchronous, active-low.
din  input  8  byte to transmit.
wr_en  input  1  push din into FIFO this cycle.
full  output  1  FIFO holds DEPTH entries.
empty  output  1  FIFO holds 0 entries.
level  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy.
tx_busy  output  1  FSM is not in IDLE (a frame is in progress).
txd  output  1  serial line; idles high; driven directly from a flop.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - txd=1, tx_busy=0, empty=1, full=0, level=0.
  - FIFO pointers cleared; FSM goes to IDLE.
  - An in-flight frame is abandoned and txd returns high on the next edge.
- Write rule:
  - wr_en=1 and full=0: din is stored and level increments at the next edge.
  - wr_en=1 and full=1: the byte is dropped and FIFO state is unchanged. This holds even if a pop occurs in the same cycle, because full is sampled before the edge.
- Pop rule: the FSM pops exactly once per frame, in the cycle it loads the shift register.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged.
- FSM states: IDLE, START, DATA, STOP. The bit counter counts 0..BIT_CYCLES-1; the bit index counts 0..7.
- IDLE:
  - txd=1.
  - If empty=0: load shift register from FIFO head, pop, go to START.
- START: txd=0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
- DATA: txd=shift[0] for BIT_CYCLES cycles, then shift right. After bit index 7, go to STOP.
- STOP:
  - txd=1 for BIT_CYCLES cycles.
  - At the end of STOP, if empty=0: load, pop and go directly to START (no extra idle cycle). Otherwise go to IDLE.
- Latency: wr_en at edge N into an empty FIFO with the FSM in IDLE gives empty=0 after N, the pop at N+1, and txd=0 after edge N+2.
- Frame length: exactly 10*BIT_CYCLES cycles.
- Throughput: back-to-back start bits are separated by exactly 10*BIT_CYCLES cycles.
- Occupancy: a byte being shifted is no longer counted in level. With the FSM busy, DEPTH additional bytes can be buffered.
- tx_busy: 1 from the cycle after the pop until STOP ends with the FIFO empty.
- Counter widths: sized with $clog2(BIT_CYCLES). No wrap beyond BIT_CYCLES-1.
- FIFO pointers are FIFO_DEPTH_LOG2 bits wide and wrap naturally. full/empty are derived from level.

Optional Feature:
Macro: UART_TX_PARITY_EN
- Defined:
  - FSM gains a PARITY state between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity) for BIT_CYCLES cycles.
  - Frame becomes 11*BIT_CYCLES cycles.
- Undefined: no PARITY state; 8N1 framing only.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Function bit_cycles(CLK_PER_HALF_BIT).
  - Constants: DATA_BITS=8, IDLE_LEVEL=1'b1.
- Sub-module uart_tx_fifo (single-clock FIFO with synchronous active-low reset, show-ahead head, level output). The FSM and shift register stay in uart_tx_unit.

Test Plan:
(All with CLK_PER_HALF_BIT=4, so BIT_CYCLES=8.)
- Single byte: write 0x55 once.
  - Start bit at txd falls 2 edges after wr_en; start bit is 8 cycles of 0.
  - Data bits in order 1,0,1,0,1,0,1,0, each 8 cycles; then 8 cycles of 1.
  - tx_busy drops 80 cycles after the start bit begins.
- Back-to-back: write 0xA5, 0x3C on consecutive cycles.
  - Second start bit begins exactly 80 cycles after the first.
  - Decoded bytes are 0xA5, 0x3C; no idle gap between frames.
- Fill/overflow: write 18 bytes (0x00..0x11) on consecutive cycles.
  - First byte is popped immediately; full=1 and level=16 after the 17th write.
  - 18th byte (0x11) is dropped; the line emits 0x00..0x10 only.
- Full with simultaneous pop: hold full, then assert wr_en on the cycle the FSM pops. The byte is dropped and level goes 16→15.
- Reset mid-frame: assert rstn=0 for 1 cycle during data bit 3 of 0xF0 with 5 bytes queued.
  - txd=1, level=0, empty=1, tx_busy=0 next cycle.
  - No further frames are sent.
- Parity (UART_TX_PARITY_EN defined): write 0x07.
  - Parity bit is 1; frame is 88 cycles.
  - Write 0x03 and the parity bit is 0.
